matmul_core_scheduler: RTL and testbench
========================================

# matmul_core_scheduler

Round-robin scheduler that shares one DAC-to-ADC matmul sequencer between NREQ requesters (host endpoint, on-chip layer controllers). It arbitrates pending requests and latches the winner's target core and iteration count. It then drives the core-select mux, triggers the sequencer, waits for it to finish, and returns a per-requester done pulse with an error flag on watchdog timeout. It sits between the requester logic and the sequencer's trigger/idle handshake.

## Interface
- NREQ, 4: number of requesters, 2..8
- CORE_W, 6: core index width (48 cores)
- SETUP_CYC, 2: cycles core_sel/seq_iteration are held stable before trigger, ≥1
- TIMEOUT, 20'd1000000: watchdog limit in cycles across TRIG+WAIT; 0 disables
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  level request per requester, held until its done
- req_core  in  NREQ*CORE_W  target core per requester, slice i = [i*CORE_W +: CORE_W]
- req_iter  in  NREQ*8  iteration count per requester, slice i = [i*8 +: 8]
- grant  out  NREQ  one-cycle one-hot pulse, winner accepted
- done  out  NREQ  one-cycle one-hot pulse, transaction finished
- err  out  1  valid with done; 1 = watchdog timeout
- busy  out  1  high in any state except IDLE
- core_sel  out  CORE_W  core select to mux, held from SETUP through DONE
- seq_iteration  out  8  iteration count to sequencer, same hold as core_sel
- seq_trigger  out  1  trigger to sequencer
- seq_idle  in  1  sequencer idle status

## Operation
- All outputs registered. Reset values: grant=0, done=0, err=0, busy=0, core_sel=0, seq_iteration=0, seq_trigger=0, rr pointer=0, state=IDLE.
- States: IDLE, SETUP, TRIG, WAIT, DONE.
- IDLE: if any req bit set, pick the first set bit scanning from pointer upward, modulo NREQ. Latch owner, core_sel, seq_iteration. Pulse grant[owner]. Load the setup counter with SETUP_CYC-1. Go to SETUP. Set pointer = (owner+1) mod NREQ.
- SETUP: decrement the counter each cycle. At 0, go to TRIG.
- TRIG: seq_trigger=1. When seq_idle==0, go to WAIT and drop seq_trigger.
- WAIT: seq_trigger=0. When seq_idle==1, go to DONE with err=0.
- Watchdog: a 20-bit counter clears on entering TRIG and increments in TRIG and WAIT. If TIMEOUT≠0 and counter==TIMEOUT-1, go to DONE with err=1 and seq_trigger=0, regardless of seq_idle.
- DONE: pulse done[owner] for one cycle, with err valid the same cycle. Then IDLE. err returns to 0 the cycle after.
- Changes to req, req_core or req_iter after grant are ignored until IDLE. A requester dropping req mid-transaction still receives done.
- A requester still asserting req after its done competes again, behind the other requesters per the pointer.
- seq_idle glitches during SETUP are ignored.

## Timing
- Request seen in IDLE at edge N: grant and busy high at N+1; state is SETUP during cycles N+1..N+SETUP_CYC.
- seq_trigger rises at edge N+SETUP_CYC+1.
- Sequencer clears seq_idle at edge T: seq_trigger low from T+1.
- Sequencer sets seq_idle at edge D: done high for cycle D+1; busy low and IDLE at D+2. Earliest next grant is D+3.
- Minimum transaction, with the sequencer responding in 1 cycle each way: SETUP_CYC+5 cycles from request to IDLE.
- Asynchronous reset mid-transaction forces all reset values immediately. No done is issued for the aborted transaction.
- Simultaneous req changes in the arbitration cycle are sampled as of that edge only.

## Test plan
- Single request: req=0001, core 17, iter 5; sequencer model idles 1 cycle, busy 10 cycles. Expected: grant=0001 at N+1, core_sel=17 and seq_iteration=5 from N+1, trigger at N+3, done=0001 with err=0, busy falls 2 cycles after seq_idle rises.
- Fairness: req=1111 held continuously. Expected: grant order 0,1,2,3,0; each done precedes the next grant; no requester is served twice before the others.
- Pointer wrap: pointer=3 after serving requester 2, req=1001. Expected: requester 3 is served, then 0.
- Watchdog: TIMEOUT=16, sequencer never drops seq_idle. Expected: seq_trigger high 16 cycles, then done with err=1, next transaction proceeds normally with err=0.
- Reset mid-WAIT: assert rst_n=0 while in WAIT. Expected: seq_trigger, busy, core_sel, grant and done at 0 immediately; no done pulse after release; pointer restarts at 0.
- Input stability: change req_core and req_iter of the owner during WAIT. Expected: core_sel and seq_iteration unchanged until DONE.

Source files
------------

// File: rtl/matmul_core_scheduler.sv
// -----------------------------------------------------------------------------
// matmul_core_scheduler
//
// Shares a single DAC-to-ADC matmul sequencer between NREQ requesters. Pending
// requests are arbitrated round-robin. The winner's core index and iteration
// count are latched and held steady for SETUP_CYC cycles. The sequencer is then
// triggered, and the scheduler waits for it to go busy and return to idle. A
// one-cycle done pulse goes back to the owner. err is set with that pulse when
// the watchdog expired instead.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req            level request per requester, held until its done
//   req_core       target core per requester, slice i = [i*CORE_W +: CORE_W]
//   req_iter       iteration count per requester, slice i = [i*8 +: 8]
//   grant          one-cycle one-hot pulse when a requester is accepted
//   done           one-cycle one-hot pulse when its transaction finishes
//   err            valid with done; 1 = watchdog timeout
//   busy           high whenever the scheduler is not idle
//   core_sel       core select to the mux, held from SETUP through DONE
//   seq_iteration  iteration count to the sequencer, same hold as core_sel
//   seq_trigger    trigger to the sequencer
//   seq_idle       sequencer idle status
// -----------------------------------------------------------------------------
module matmul_core_scheduler #(
    parameter int          NREQ      = 4,
    parameter int          CORE_W    = 6,
    parameter int          SETUP_CYC = 2,
    parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CORE_W-1:0]   req_core,
    input  logic [NREQ*8-1:0]        req_iter,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy,
    output logic [CORE_W-1:0]        core_sel,
    output logic [7:0]               seq_iteration,
    output logic                     seq_trigger,
    input  logic                     seq_idle
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [SC_W-1:0]  SETUP_LOAD = SC_W'(SETUP_CYC - 1);
    localparam logic [19:0]      WD_LIMIT   = TIMEOUT - 20'd1;
    localparam logic [NREQ-1:0]  ONE_HOT0   = NREQ'(1);

    typedef enum logic [2:0] {IDLE, SETUP, TRIG, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  owner_reg, owner_next;
    logic [SC_W-1:0]   setup_cnt_reg, setup_cnt_next;
    logic [19:0]       wd_cnt_reg, wd_cnt_next;

    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic [CORE_W-1:0] core_sel_reg, core_sel_next;
    logic [7:0]        seq_iteration_reg, seq_iteration_next;
    logic              seq_trigger_reg, seq_trigger_next;

    // Per-requester views of the packed request buses, and the requester
    // index visited at each scan offset from the round-robin pointer.
    logic [CORE_W-1:0] core_arr [NREQ];
    logic [7:0]        iter_arr [NREQ];
    logic [PTR_W:0]    cand_sum [NREQ];
    logic [PTR_W-1:0]  cand_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign core_arr[gi] = req_core[gi*CORE_W +: CORE_W];
            assign iter_arr[gi] = req_iter[gi*8 +: 8];
            assign cand_sum[gi] = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (PTR_W+1)'(NREQ))
                                ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(NREQ))
                                : PTR_W'(cand_sum[gi]);
        end
    endgenerate

    // Scan from the largest offset down so the smallest offset (closest to
    // the pointer) wins without needing an early exit.
    logic             arb_found;
    logic [PTR_W-1:0] arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[cand_idx[off]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx[off];
            end
        end
    end

    // The watchdog only counts in TRIG/WAIT. A zero limit disables it.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 20'd0) && (wd_cnt_reg == WD_LIMIT) &&
                         ((state_reg == TRIG) || (state_reg == WAIT));

    // State and transaction context register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            setup_cnt_reg <= '0;
            wd_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            setup_cnt_reg <= setup_cnt_next;
            wd_cnt_reg    <= wd_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        setup_cnt_next = setup_cnt_reg;
        wd_cnt_next    = wd_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next     = SETUP;
                    owner_next     = arb_idx;
                    ptr_next       = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + PTR_W'(1);
                    setup_cnt_next = SETUP_LOAD;
                end
            end
            SETUP: begin
                // Clearing here means the watchdog starts at 0 on entry to TRIG.
                wd_cnt_next = '0;
                if (setup_cnt_reg == '0) begin
                    state_next = TRIG;
                end else begin
                    setup_cnt_next = setup_cnt_reg - SC_W'(1);
                end
            end
            TRIG: begin
                wd_cnt_next = wd_cnt_reg + 20'd1;
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (!seq_idle) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                wd_cnt_next = wd_cnt_reg + 20'd1;
                if (timeout_hit || seq_idle) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        grant_next         = '0;
        core_sel_next      = core_sel_reg;
        seq_iteration_next = seq_iteration_reg;
        if ((state_reg == IDLE) && arb_found) begin
            grant_next         = ONE_HOT0 << arb_idx;
            core_sel_next      = core_arr[arb_idx];
            seq_iteration_next = iter_arr[arb_idx];
        end
        done_next        = (state_next == DONE) ? (ONE_HOT0 << owner_reg) : '0;
        err_next         = (state_next == DONE) && timeout_hit;
        busy_next        = (state_next != IDLE);
        seq_trigger_next = (state_next == TRIG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg         <= '0;
            done_reg          <= '0;
            err_reg           <= 1'b0;
            busy_reg          <= 1'b0;
            core_sel_reg      <= '0;
            seq_iteration_reg <= '0;
            seq_trigger_reg   <= 1'b0;
        end else begin
            grant_reg         <= grant_next;
            done_reg          <= done_next;
            err_reg           <= err_next;
            busy_reg          <= busy_next;
            core_sel_reg      <= core_sel_next;
            seq_iteration_reg <= seq_iteration_next;
            seq_trigger_reg   <= seq_trigger_next;
        end
    end

    assign grant         = grant_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign busy          = busy_reg;
    assign core_sel      = core_sel_reg;
    assign seq_iteration = seq_iteration_reg;
    assign seq_trigger   = seq_trigger_reg;

endmodule

// File: tb/tb_matmul_core_scheduler.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for matmul_core_scheduler. Stimulus pushes the expected
// grant and done records into queues. A negedge monitor pops a record and
// compares it whenever the DUT presents a grant or done pulse. A behavioural
// sequencer answers seq_trigger. It can also be made to hang for the
// watchdog test.
// -----------------------------------------------------------------------------
module tb_matmul_core_scheduler;

    localparam int NREQ   = 4;
    localparam int CORE_W = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*CORE_W-1:0] req_core;
    logic [NREQ*8-1:0]      req_iter;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic                   busy;
    logic [CORE_W-1:0]      core_sel;
    logic [7:0]             seq_iteration;
    logic                   seq_trigger;
    logic                   seq_idle;

    matmul_core_scheduler #(
        .NREQ      (NREQ),
        .CORE_W    (CORE_W),
        .SETUP_CYC (2),
        .TIMEOUT   (20'd16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_core      (req_core),
        .req_iter      (req_iter),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .core_sel      (core_sel),
        .seq_iteration (seq_iteration),
        .seq_trigger   (seq_trigger),
        .seq_idle      (seq_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]   who;
        logic              err;
        logic [CORE_W-1:0] core;
        logic [7:0]        iter;
    } exp_t;

    exp_t grant_q[$];
    exp_t done_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int outstanding = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- sequencer model ----------------
    bit seq_stuck = 1'b0;
    int seq_phase = 0;
    int seq_cnt   = 0;

    initial begin
        seq_idle = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                seq_phase = 0;
                seq_idle  = 1'b1;
            end else if (seq_phase == 0) begin
                if (seq_trigger && !seq_stuck) begin
                    seq_idle  = 1'b0;
                    seq_cnt   = 10;
                    seq_phase = 1;
                end
            end else begin
                seq_cnt--;
                if (seq_cnt == 0) begin
                    seq_idle  = 1'b1;
                    seq_phase = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_g;
    exp_t mon_d;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            outstanding = 0;
        end else begin
            if (grant != '0) begin
                if (grant_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_grant: got %b, expected no grant", grant);
                end else begin
                    mon_g = grant_q.pop_front();
                    check("grant_onehot", grant, mon_g.who);
                    check("grant_core_sel", core_sel, mon_g.core);
                    check("grant_seq_iteration", seq_iteration, mon_g.iter);
                    check("grant_busy", busy, 1);
                    check("grant_after_prev_done", outstanding, 0);
                end
                outstanding++;
            end
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got %b, expected no done", done);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_onehot", done, mon_d.who);
                    check("done_err", err, mon_d.err);
                    check("done_core_sel_held", core_sel, mon_d.core);
                    check("done_seq_iteration_held", seq_iteration, mon_d.iter);
                    check("done_busy", busy, 1);
                    $display("txn done=%b err=%0d core_sel=%0d seq_iteration=%0d t=%0t",
                             done, err, core_sel, seq_iteration, $time);
                end
                outstanding--;
            end else begin
                check("err_without_done", err, 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_core_sel"}, core_sel, 0);
        check({tag, "_seq_iteration"}, seq_iteration, 0);
        check({tag, "_seq_trigger"}, seq_trigger, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic exp_t mk_exp(input int idx, input logic [CORE_W-1:0] core,
                                    input logic [7:0] iter, input logic e);
        exp_t r;
        logic [NREQ-1:0] one;
        one    = NREQ'(1);
        r.who  = one << idx;
        r.err  = e;
        r.core = core;
        r.iter = iter;
        return r;
    endfunction

    task automatic wait_done(input string name, output logic [NREQ-1:0] who);
        who = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done != '0) begin
                who = done;
                break;
            end
        end
        if (who == '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no done within 300 cycles, expected one", name);
        end
    endtask

    // One transaction for requester idx. Returns the trigger latency (in
    // cycles after req is applied), the trigger high time, and the delay from
    // the rise of seq_idle to busy low.
    task automatic run_txn(input int idx, input logic [CORE_W-1:0] core, input logic [7:0] iter,
                           input logic exp_err, input bit mutate,
                           output int trig_lat, output int trig_cyc, output int busy_dly);
        exp_t e;
        bit   seen_trig = 1'b0;
        bit   mutated   = 1'b0;
        bit   got       = 1'b0;
        int   rise_k    = -1;
        int   done_k    = -1;
        logic prev_idle;
        req_core[idx*CORE_W +: CORE_W] = core;
        req_iter[idx*8 +: 8]           = iter;
        e = mk_exp(idx, core, iter, exp_err);
        grant_q.push_back(e);
        done_q.push_back(e);
        trig_lat  = -1;
        trig_cyc  = 0;
        busy_dly  = -1;
        prev_idle = seq_idle;
        req[idx]  = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (seq_trigger) begin
                trig_cyc++;
                if (!seen_trig) begin
                    seen_trig = 1'b1;
                    trig_lat  = k;
                end
            end
            if (mutate && seen_trig && !seq_trigger && !mutated) begin
                req_core[idx*CORE_W +: CORE_W] = ~core;
                req_iter[idx*8 +: 8]           = ~iter;
                mutated = 1'b1;
            end
            if (seq_idle && !prev_idle) rise_k = k;
            prev_idle = seq_idle;
            if (done[idx]) begin
                got    = 1'b1;
                done_k = k;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL txn_timeout_req%0d: no done within 300 cycles, expected one", idx);
        end
        req[idx] = 1'b0;
        @(negedge clk);
        check("busy_low_after_done", busy, 0);
        if (rise_k >= 0) busy_dly = done_k + 1 - rise_k;
    endtask

    // ---------------- main stimulus ----------------
    int trig_lat, trig_cyc, busy_dly;
    logic [NREQ-1:0] who;
    int done_seen;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_core = '0;
        req_iter = '0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: core 17, iteration 5
        run_txn(0, 6'd17, 8'd5, 1'b0, 1'b0, trig_lat, trig_cyc, busy_dly);
        check("single_trigger_latency", trig_lat, 3);
        check("single_trigger_width", trig_cyc, 1);
        check("single_busy_fall_delay", busy_dly, 2);
        repeat (3) @(negedge clk);

        // Fairness: all four held; pointer starts at 0 after reset
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_core[i*CORE_W +: CORE_W] = CORE_W'(10 + i);
            req_iter[i*8 +: 8]           = 8'(20 + i);
        end
        for (int n = 0; n < 5; n++) begin
            grant_q.push_back(mk_exp(n % NREQ, CORE_W'(10 + n % NREQ), 8'(20 + n % NREQ), 1'b0));
            done_q.push_back(mk_exp(n % NREQ, CORE_W'(10 + n % NREQ), 8'(20 + n % NREQ), 1'b0));
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) wait_done("fairness_done", who);
        req = '0;
        repeat (3) @(negedge clk);

        // Pointer wrap: serve 2 (pointer -> 3), then 1001 gives 3 then 0
        run_txn(2, 6'd33, 8'd7, 1'b0, 1'b0, trig_lat, trig_cyc, busy_dly);
        req_core[3*CORE_W +: CORE_W] = 6'd47;
        req_iter[3*8 +: 8]           = 8'd99;
        req_core[0*CORE_W +: CORE_W] = 6'd1;
        req_iter[0*8 +: 8]           = 8'd255;
        grant_q.push_back(mk_exp(3, 6'd47, 8'd99, 1'b0));
        done_q.push_back(mk_exp(3, 6'd47, 8'd99, 1'b0));
        grant_q.push_back(mk_exp(0, 6'd1, 8'd255, 1'b0));
        done_q.push_back(mk_exp(0, 6'd1, 8'd255, 1'b0));
        req = 4'b1001;
        wait_done("wrap_done_a", who);
        req = req & ~who;
        wait_done("wrap_done_b", who);
        req = req & ~who;
        repeat (3) @(negedge clk);

        // Watchdog: sequencer never leaves idle
        seq_stuck = 1'b1;
        run_txn(1, 6'd40, 8'd9, 1'b1, 1'b0, trig_lat, trig_cyc, busy_dly);
        check("watchdog_trigger_width", trig_cyc, 16);
        seq_stuck = 1'b0;
        repeat (2) @(negedge clk);

        // Normal transaction after timeout; owner's inputs change during WAIT
        run_txn(2, 6'd45, 8'd200, 1'b0, 1'b1, trig_lat, trig_cyc, busy_dly);
        check("post_watchdog_trigger_width", trig_cyc, 1);
        repeat (2) @(negedge clk);

        // Reset mid-WAIT: requester 1 (pointer at 3 -> wins, pointer -> 2)
        req_core[1*CORE_W +: CORE_W] = 6'd9;
        req_iter[1*8 +: 8]           = 8'd3;
        grant_q.push_back(mk_exp(1, 6'd9, 8'd3, 1'b0));
        req[1] = 1'b1;
        begin
            bit seen   = 1'b0;
            bit in_wait = 1'b0;
            for (int k = 0; k < 100 && !in_wait; k++) begin
                @(negedge clk);
                if (seq_trigger) seen = 1'b1;
                else if (seen && busy) in_wait = 1'b1;
            end
            check("reached_wait", in_wait, 1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done != '0) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);

        // Pointer restarts at 0: 0110 serves 1 before 2
        req_core[1*CORE_W +: CORE_W] = 6'd21;
        req_iter[1*8 +: 8]           = 8'd11;
        req_core[2*CORE_W +: CORE_W] = 6'd22;
        req_iter[2*8 +: 8]           = 8'd12;
        grant_q.push_back(mk_exp(1, 6'd21, 8'd11, 1'b0));
        done_q.push_back(mk_exp(1, 6'd21, 8'd11, 1'b0));
        grant_q.push_back(mk_exp(2, 6'd22, 8'd12, 1'b0));
        done_q.push_back(mk_exp(2, 6'd22, 8'd12, 1'b0));
        req = 4'b0110;
        wait_done("restart_done_a", who);
        req = req & ~who;
        wait_done("restart_done_b", who);
        req = req & ~who;
        repeat (4) @(negedge clk);

        check("grant_queue_drained", grant_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion before 500000");
        $fatal(1, "global timeout");
    end

endmodule
